// File: rtl/clock_ctrl_fsm.sv
// Front-panel controller: debounces four push-buttons, tracks mode and edit
// position, and emits one-cycle count pulses for the time and alarm counters.
module clock_ctrl_fsm #(
  parameter int unsigned DEBOUNCE_CNT = 500000,
  parameter int unsigned DB_W         = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw_mode_n,
  input  logic       i_sw_pos_n,
  input  logic       i_sw_inc_n,
  input  logic       i_sw_alarm_n,
  input  logic       i_tick_1hz,
  input  logic       i_max_hit_sec,
  input  logic       i_max_hit_min,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_sec_clk,
  output logic       o_min_clk,
  output logic       o_hour_clk,
  output logic       o_alarm_sec_clk,
  output logic       o_alarm_min_clk,
  output logic       o_alarm_hour_clk,
  output logic       o_alarm_en
);

  typedef enum logic [1:0] {CLOCK = 2'd0, SETUP = 2'd1, ALARM = 2'd2} mode_t;
  typedef enum logic [1:0] {SEC = 2'd0, MIN = 2'd1, HOUR = 2'd2} pos_t;

  localparam int BTN_MODE  = 0;
  localparam int BTN_POS   = 1;
  localparam int BTN_INC   = 2;
  localparam int BTN_ALARM = 3;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CNT - 1);

  logic [3:0]      raw, sync1, sync2, db, db_prev, press;
  logic [DB_W-1:0] cnt [4];
  logic [1:0]      hit_prev;
  logic            sec_carry, min_carry, inc_ok;

  mode_t      mode, mode_next;
  pos_t       pos, pos_next;
  logic       alarm_en, alarm_en_next;
  logic [2:0] inc_sel;
  logic [2:0] time_clk, time_clk_next;
  logic [2:0] alarm_clk, alarm_clk_next;

  assign raw = {i_sw_alarm_n, i_sw_inc_n, i_sw_pos_n, i_sw_mode_n};

  // Button path: 2-FF synchroniser, then a run-length debouncer per button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '1;
      sync2   <= '1;
      db      <= '1;
      db_prev <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      db_prev <= db;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Only the debounced falling edge is a press; release is silent
  assign press     = db_prev & ~db;
  assign sec_carry = i_max_hit_sec & ~hit_prev[0];
  assign min_carry = i_max_hit_min & ~hit_prev[1];
  assign inc_ok    = press[BTN_INC] & ~press[BTN_MODE] & ~press[BTN_POS];

  always_comb begin
    mode_next      = mode;
    pos_next       = pos;
    alarm_en_next  = alarm_en ^ press[BTN_ALARM];
    inc_sel        = 3'b000;
    time_clk_next  = 3'b000;
    alarm_clk_next = 3'b000;

    if (press[BTN_MODE]) begin
      pos_next = SEC;
      case (mode)
        CLOCK:   mode_next = SETUP;
        SETUP:   mode_next = ALARM;
        default: mode_next = CLOCK;
      endcase
    end else if (press[BTN_POS] && mode != CLOCK) begin
      case (pos)
        SEC:     pos_next = MIN;
        MIN:     pos_next = HOUR;
        default: pos_next = SEC;
      endcase
    end

    if (inc_ok) begin
      case (pos)
        SEC:     inc_sel = 3'b001;
        MIN:     inc_sel = 3'b010;
        default: inc_sel = 3'b100;
      endcase
    end

    // SETUP freezes timekeeping; only increments reach the time counters
    if (mode == SETUP) begin
      time_clk_next = inc_sel;
    end else begin
      time_clk_next = {min_carry, sec_carry, i_tick_1hz};
      if (mode == ALARM) alarm_clk_next = inc_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode      <= CLOCK;
      pos       <= SEC;
      alarm_en  <= 1'b0;
      time_clk  <= '0;
      alarm_clk <= '0;
      hit_prev  <= '0;
    end else begin
      mode      <= mode_next;
      pos       <= pos_next;
      alarm_en  <= alarm_en_next;
      time_clk  <= time_clk_next;
      alarm_clk <= alarm_clk_next;
      hit_prev  <= {i_max_hit_min, i_max_hit_sec};
    end
  end

  assign o_mode           = mode;
  assign o_position       = pos;
  assign o_sec_clk        = time_clk[0];
  assign o_min_clk        = time_clk[1];
  assign o_hour_clk       = time_clk[2];
  assign o_alarm_sec_clk  = alarm_clk[0];
  assign o_alarm_min_clk  = alarm_clk[1];
  assign o_alarm_hour_clk = alarm_clk[2];
  assign o_alarm_en       = alarm_en;

endmodule
